// File: rtl/exc_pkg.sv
// Shared types and constants for the pipeline exception controller.
package exc_pkg;

  localparam int unsigned CODE_W = 4;
  localparam int unsigned VEC_W  = 64;

  typedef enum logic [2:0] {
    IDLE,
    TAKE,
    HANDLER,
    ACKED,
    RETURN
  } exc_state_t;

  localparam logic [2:0] FLUSH_NONE = 3'b000;
  localparam logic [2:0] FLUSH_ALL  = 3'b111;
  localparam logic [2:0] FLUSH_FE   = 3'b011;

  localparam logic [CODE_W-1:0] CODE_NONE = 4'd0;

  // Vector for source index idx (code idx+1); 64-bit arithmetic, wraps naturally.
  function automatic logic [VEC_W-1:0] vec_of(input logic [VEC_W-1:0]  base,
                                               input logic [VEC_W-1:0]  stride,
                                               input logic [CODE_W-1:0] idx);
    return base + VEC_W'(idx) * stride;
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder: lowest set bit of pending wins.
module exc_prio_enc
  import exc_pkg::*;
#(
  parameter int unsigned NSRC = 4
) (
  input  logic [NSRC-1:0]   pending,
  output logic              valid,
  output logic [CODE_W-1:0] index,
  output logic [NSRC-1:0]   onehot
);

  always_comb begin
    valid  = |pending;
    index  = '0;
    onehot = '0;
    // Scan high to low so the lowest set bit is the last one written.
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (pending[i]) begin
        index     = CODE_W'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exc_controller.sv
// Exception sequencer: arbitrates requests, issues Exc/flush, tracks the
// handler through ExcAck and Eret.
module exc_controller
  import exc_pkg::*;
#(
  parameter int unsigned      NSRC       = 4,
  parameter logic [VEC_W-1:0] VEC_BASE   = 64'h00000000000000D8,
  parameter logic [VEC_W-1:0] VEC_STRIDE = 64'h0000000000000010,
  parameter int unsigned      CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSRC-1:0]   exc_req,
  input  logic [NSRC-1:0]   exc_en,
  input  logic              mem_busy,
  input  logic              ExcAck,
  input  logic              Eret,
  output logic              Exc,
  output logic [VEC_W-1:0]  Exc_vector,
  output logic [CODE_W-1:0] EStatusI,
  output logic [NSRC-1:0]   src_ack,
  output logic [2:0]        flush,
  output logic              in_handler,
  output logic [CNT_W-1:0]  exc_count
);

  if (NSRC < 1 || NSRC > 15) begin : g_nsrc_check
    $error("exc_controller: NSRC must be in 1..15 to fit the 4-bit code");
  end

  exc_state_t        r_state;
  logic              r_exc;
  logic [VEC_W-1:0]  r_vector;
  logic [CODE_W-1:0] r_code;
  logic [NSRC-1:0]   r_src_ack;
  logic [2:0]        r_flush;
  logic              r_in_handler;
  logic [CNT_W-1:0]  r_exc_count;

  logic [NSRC-1:0]   w_pending;
  logic              w_valid;
  logic [CODE_W-1:0] w_index;
  logic [NSRC-1:0]   w_onehot;

  assign w_pending = exc_req & exc_en;

  exc_prio_enc #(
    .NSRC (NSRC)
  ) u_prio_enc (
    .pending (w_pending),
    .valid   (w_valid),
    .index   (w_index),
    .onehot  (w_onehot)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_exc        <= 1'b0;
      r_vector     <= '0;
      r_code       <= CODE_NONE;
      r_src_ack    <= '0;
      r_flush      <= FLUSH_NONE;
      r_in_handler <= 1'b0;
      r_exc_count  <= '0;
    end else begin
      // Strobes are single-cycle; only the transitions below raise them.
      r_exc     <= 1'b0;
      r_src_ack <= '0;
      r_flush   <= FLUSH_NONE;
      case (r_state)
        IDLE: begin
          if (w_valid && !mem_busy) begin
            r_state      <= TAKE;
            r_exc        <= 1'b1;
            r_flush      <= FLUSH_ALL;
            r_src_ack    <= w_onehot;
            r_in_handler <= 1'b1;
            r_code       <= w_index + CODE_W'(1);
            r_vector     <= vec_of(VEC_BASE, VEC_STRIDE, w_index);
            if (r_exc_count != '1) begin
              r_exc_count <= r_exc_count + CNT_W'(1);
            end
          end
        end
        TAKE: begin
          r_state <= HANDLER;
        end
        HANDLER: begin
          if (Eret) begin
            r_state <= RETURN;
            r_flush <= FLUSH_FE;
          end else if (ExcAck) begin
            r_state <= ACKED;
          end
        end
        ACKED: begin
          if (Eret) begin
            r_state <= RETURN;
            r_flush <= FLUSH_FE;
          end
        end
        RETURN: begin
          r_state      <= IDLE;
          r_in_handler <= 1'b0;
          r_code       <= CODE_NONE;
          r_vector     <= '0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign Exc        = r_exc;
  assign Exc_vector = r_vector;
  assign EStatusI   = r_code;
  assign src_ack    = r_src_ack;
  assign flush      = r_flush;
  assign in_handler = r_in_handler;
  assign exc_count  = r_exc_count;

endmodule

// File: tb/tb_exc_controller.sv
// Self-checking bench for exc_controller: directed scenarios plus random
// traffic compared every cycle against a behavioural model.
module tb_exc_controller;

  localparam int unsigned NSRC  = 4;
  localparam int unsigned CNT_W = 8;
  localparam logic [63:0] VB    = 64'hD8;
  localparam logic [63:0] VS    = 64'h10;

  logic             clk;
  logic             reset;
  logic [NSRC-1:0]  exc_req;
  logic [NSRC-1:0]  exc_en;
  logic             mem_busy;
  logic             ExcAck;
  logic             Eret;
  logic             Exc;
  logic [63:0]      Exc_vector;
  logic [3:0]       EStatusI;
  logic [NSRC-1:0]  src_ack;
  logic [2:0]       flush;
  logic             in_handler;
  logic [CNT_W-1:0] exc_count;

  exc_controller #(
    .NSRC       (NSRC),
    .VEC_BASE   (VB),
    .VEC_STRIDE (VS),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .exc_req    (exc_req),
    .exc_en     (exc_en),
    .mem_busy   (mem_busy),
    .ExcAck     (ExcAck),
    .Eret       (Eret),
    .Exc        (Exc),
    .Exc_vector (Exc_vector),
    .EStatusI   (EStatusI),
    .src_ack    (src_ack),
    .flush      (flush),
    .in_handler (in_handler),
    .exc_count  (exc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: what the outputs must be after each edge.
  bit          m_exc;
  logic [63:0] m_vec;
  logic [3:0]  m_code;
  logic [3:0]  m_ack;
  logic [2:0]  m_flush;
  bit          m_inh;
  bit          m_ret;
  int          m_cnt;

  function automatic int lowest(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (p[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    logic [3:0] pend;
    int w;
    if (!reset) begin
      m_exc = 0; m_vec = '0; m_code = '0; m_ack = '0;
      m_flush = '0; m_inh = 0; m_ret = 0; m_cnt = 0;
    end else begin
      pend = exc_req & exc_en;
      if (m_ret) begin
        m_ret = 0; m_inh = 0; m_code = '0; m_vec = '0; m_flush = '0;
      end else if (m_exc) begin
        m_exc = 0; m_ack = '0; m_flush = '0;
      end else if (m_inh) begin
        // Acknowledge or not, the handler ends only on Eret.
        if (Eret) begin
          m_ret = 1; m_flush = 3'b011;
        end
      end else if (pend != 0 && !mem_busy) begin
        w       = lowest(pend);
        m_exc   = 1;
        m_inh   = 1;
        m_code  = 4'(w + 1);
        m_vec   = VB + 64'(w) * VS;
        m_ack   = 4'(1 << w);
        m_flush = 3'b111;
        m_cnt   = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
    end
  end

  always @(negedge clk) begin
    if (reset && chk_en) begin
      chk("m.Exc",        64'(Exc),        64'(m_exc));
      chk("m.Exc_vector", Exc_vector,      m_vec);
      chk("m.EStatusI",   64'(EStatusI),   64'(m_code));
      chk("m.src_ack",    64'(src_ack),    64'(m_ack));
      chk("m.flush",      64'(flush),      64'(m_flush));
      chk("m.in_handler", 64'(in_handler), 64'(m_inh));
      chk("m.exc_count",  64'(exc_count),  64'(m_cnt));
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, ".Exc"},        64'(Exc),        64'd0);
    chk({tag, ".Exc_vector"}, Exc_vector,      64'd0);
    chk({tag, ".EStatusI"},   64'(EStatusI),   64'd0);
    chk({tag, ".src_ack"},    64'(src_ack),    64'd0);
    chk({tag, ".flush"},      64'(flush),      64'd0);
    chk({tag, ".in_handler"}, 64'(in_handler), 64'd0);
    chk({tag, ".exc_count"},  64'(exc_count),  64'd0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exc_req = '0; exc_en = 4'hF; mem_busy = 0; ExcAck = 0; Eret = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    reset  = 1'b1;
    chk_en = 1'b1;

    // Single request
    exc_req = 4'b0100;
    after_edge();
    chk("t1.Exc",      64'(Exc),       64'd1);
    chk("t1.EStatusI", 64'(EStatusI),  64'd3);
    chk("t1.vector",   Exc_vector,     64'hF8);
    chk("t1.src_ack",  64'(src_ack),   64'b0100);
    chk("t1.flush",    64'(flush),     64'b111);
    chk("t1.count",    64'(exc_count), 64'd1);
    @(negedge clk); exc_req = '0;
    repeat (2) @(negedge clk); ExcAck = 1;
    @(negedge clk); ExcAck = 0;
    repeat (2) @(negedge clk); Eret = 1; exc_req = 4'b0010;
    after_edge();
    chk("t1.ret_flush", 64'(flush),      64'b011);
    chk("t1.ret_inh",   64'(in_handler), 64'd1);
    chk("t1.ret_exc",   64'(Exc),        64'd0);
    @(negedge clk); Eret = 0;
    after_edge();
    chk("t1.gap_exc",  64'(Exc),        64'd0);
    chk("t1.gap_inh",  64'(in_handler), 64'd0);
    chk("t1.gap_code", 64'(EStatusI),   64'd0);
    after_edge();
    chk("t1.next_exc",  64'(Exc),      64'd1);
    chk("t1.next_code", 64'(EStatusI), 64'd2);
    chk("t1.next_vec",  Exc_vector,    64'hE8);
    @(negedge clk); exc_req = '0;
    @(negedge clk); ExcAck = 1; Eret = 1;
    after_edge();
    chk("both.flush", 64'(flush), 64'b011);
    @(negedge clk); ExcAck = 0; Eret = 0;

    // Priority and masking
    @(negedge clk); exc_req = 4'b1010; exc_en = 4'b1101;
    after_edge();
    chk("t2.code",    64'(EStatusI), 64'd4);
    chk("t2.vector",  Exc_vector,    64'h108);
    chk("t2.src_ack", 64'(src_ack),  64'b1000);
    @(negedge clk); exc_req = 4'b0010;
    @(negedge clk); Eret = 1;
    @(negedge clk); Eret = 0;
    repeat (4) @(negedge clk);
    chk("t2.masked_exc", 64'(Exc),        64'd0);
    chk("t2.masked_inh", 64'(in_handler), 64'd0);
    exc_req = '0; exc_en = 4'hF;

    // Eret while idle
    @(negedge clk); Eret = 1;
    after_edge();
    chk("idle_eret.flush", 64'(flush),      64'd0);
    chk("idle_eret.inh",   64'(in_handler), 64'd0);
    @(negedge clk); Eret = 0;

    // mem_busy holds off the take
    mem_busy = 1; exc_req = 4'b0001;
    repeat (5) begin
      after_edge();
      chk("busy.Exc", 64'(Exc), 64'd0);
    end
    @(negedge clk); mem_busy = 0;
    after_edge();
    chk("busy.rel_exc",  64'(Exc),      64'd1);
    chk("busy.rel_code", 64'(EStatusI), 64'd1);
    chk("busy.rel_vec",  Exc_vector,    64'hD8);

    // Asynchronous reset inside the handler
    @(negedge clk); exc_req = '0;
    @(negedge clk); exc_req = 4'b0100;
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_all_zero("mid_rst");
    @(negedge clk); reset = 1'b1;
    after_edge();
    chk("rst_retake.exc",   64'(Exc),       64'd1);
    chk("rst_retake.code",  64'(EStatusI),  64'd3);
    chk("rst_retake.count", 64'(exc_count), 64'd1);
    @(negedge clk); exc_req = '0;
    @(negedge clk); Eret = 1;
    @(negedge clk); Eret = 0;
    repeat (2) @(negedge clk);

    // Random traffic with well-behaved sources
    repeat (2000) begin
      @(negedge clk);
      exc_req = exc_req & ~src_ack;
      if ($urandom % 6 == 0) exc_req[$urandom % 4] = 1'b1;
      if ($urandom % 40 == 0) exc_req = exc_req & ~(4'(1) << ($urandom % 4));
      exc_en   = ($urandom % 8 == 0) ? 4'($urandom) : 4'hF;
      mem_busy = ($urandom % 4 == 0);
      ExcAck   = in_handler && ($urandom % 4 == 0);
      Eret     = ($urandom % 5 == 0);
    end
    @(negedge clk);
    exc_req = '0; exc_en = 4'hF; mem_busy = 0; ExcAck = 0; Eret = 1;
    repeat (5) @(negedge clk);

    // Back-to-back exceptions until the counter saturates
    exc_req = 4'b0001;
    repeat (1300) @(negedge clk);
    exc_req = '0;
    repeat (5) @(negedge clk);
    Eret = 0;
    chk("sat.count", 64'(exc_count),  64'd255);
    chk("sat.inh",   64'(in_handler), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
